// File: rtl/compare_iter_unit.sv
// Multi-cycle MSB-first magnitude comparator with early exit and valid/ready handshakes.
// Optional branch-condition evaluation (funct3 in, taken out) when BR_FUNCT_EN is defined.
module compare_iter_unit #(
    parameter int unsigned W = 32,
    parameter int unsigned C = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
`ifdef BR_FUNCT_EN
    input  logic [2:0]   funct3,
    output logic         taken,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    localparam int unsigned N  = (C == 0) ? 1 : W / C;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IdxTop = IW'(N - 1);

    if (C == 0 || (W % C) != 0) begin : g_bad_params
        $error("compare_iter_unit: W must be a non-zero multiple of C");
    end

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [C-1:0]  chunk_a;
    logic [C-1:0]  chunk_b;
    logic          mode;
    logic [W-1:0]  flip;

`ifdef BR_FUNCT_EN
    logic [2:0] funct_q;

    function automatic logic br_taken(input logic [2:0] f, input logic is_eq,
                                      input logic is_lt);
        logic r;
        r = 1'b0;
        case (f)
            3'b000:          r = is_eq;
            3'b001:          r = !is_eq;
            3'b100, 3'b110:  r = is_lt;
            3'b101, 3'b111:  r = !is_lt;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    assign mode = ~funct3[1];
`else
    assign mode = sgn;
`endif

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign flip = W'(mode) << (W - 1);

    assign chunk_a  = a_q[idx*C +: C];
    assign chunk_b  = b_q[idx*C +: C];
    assign in_ready = (state == StIdle) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
`ifdef BR_FUNCT_EN
            funct_q   <= 3'b000;
            taken     <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= a ^ flip;
                        b_q   <= b ^ flip;
                        idx   <= IdxTop;
                        eq    <= 1'b0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
`ifdef BR_FUNCT_EN
                        funct_q <= funct3;
                        taken   <= 1'b0;
`endif
                        state <= StScan;
                    end
                end
                StScan: begin
                    if (chunk_a != chunk_b) begin
                        gt        <= chunk_a > chunk_b;
                        lt        <= chunk_a < chunk_b;
                        out_valid <= 1'b1;
`ifdef BR_FUNCT_EN
                        taken     <= br_taken(funct_q, 1'b0, chunk_a < chunk_b);
`endif
                        state     <= StDone;
                    end else if (idx == '0) begin
                        eq        <= 1'b1;
                        out_valid <= 1'b1;
`ifdef BR_FUNCT_EN
                        taken     <= br_taken(funct_q, 1'b1, 1'b0);
`endif
                        state     <= StDone;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_iter_unit.sv
// Directed bench for compare_iter_unit (W=32, C=8); branch tests run when BR_FUNCT_EN is defined.
module tb_compare_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [2:0]  funct3;
    logic        taken;
    logic        out_valid;
    logic        out_ready;
    logic        eq;
    logic        gt;
    logic        lt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    compare_iter_unit #(.W(32), .C(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
`ifdef BR_FUNCT_EN
        .funct3    (funct3),
        .taken     (taken),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

`ifndef BR_FUNCT_EN
    assign taken = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one transaction, measure latency, check result; leaves DUT in DONE.
    task automatic start_and_wait(input logic [31:0] op_a, input logic [31:0] op_b,
                                  input logic s, input logic [2:0] f,
                                  input logic [2:0] exp_egl, input int exp_lat,
                                  input logic exp_taken, input string name);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        a = op_a; b = op_b; sgn = s; funct3 = f; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Changes after accept must not disturb the result.
        a = ~op_a; b = op_a; sgn = ~s; funct3 = ~f;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt + 1 !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, cnt + 1, exp_lat);
        end
        checks++;
        if ({eq, gt, lt} !== exp_egl) begin
            failures++;
            $display("FAIL %s eq/gt/lt: got %b expected %b", name, {eq, gt, lt}, exp_egl);
        end
`ifdef BR_FUNCT_EN
        checks++;
        if (taken !== exp_taken) begin
            failures++;
            $display("FAIL %s taken: got %b expected %b", name, taken, exp_taken);
        end
`else
        if (exp_taken === 1'bx) $display("unexpected taken argument in %s", name);
`endif
    endtask

    task automatic finish_handshake(input string name);
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s post-handshake: out_valid=%b in_ready=%b expected 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic run(input logic [31:0] op_a, input logic [31:0] op_b, input logic s,
                       input logic [2:0] exp_egl, input int exp_lat, input string name);
        out_ready = 1'b1;
        start_and_wait(op_a, op_b, s, 3'b000, exp_egl, exp_lat, exp_egl[2], name);
        finish_handshake(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'h1; b = 32'h2; sgn = 1'b0; funct3 = 3'b000;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, eq, gt, lt} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got %b expected 00000",
                     {in_ready, out_valid, eq, gt, lt});
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready: got %b expected 1", in_ready);
        end
`ifdef BR_FUNCT_EN
        checks++;
        if (taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_taken: got %b expected 0", taken);
        end
`endif
    endtask

    task automatic test_compare();
        run(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010, 2, "case1_unsigned");
        run(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, 2, "case2_signed");
        run(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'b100, 5, "case3_equal");
        run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 3'b010, 5, "case4_signed");
        run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 3'b010, 5, "case4_unsigned");
        run(32'h0001_0000, 32'h0002_0000, 1'b0, 3'b001, 3, "mid_chunk_lt");
        run(32'h0000_0000, 32'h0000_0000, 1'b0, 3'b100, 5, "zero_equal");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_and_wait(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b000, 3'b010, 2, 1'b0, "case5");
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, gt, in_ready} !== 3'b110) begin
                failures++;
                $display("FAIL case5_hold cycle %0d: out_valid/gt/in_ready=%b expected 110",
                         i, {out_valid, gt, in_ready});
            end
        end
        finish_handshake("case5");
        run(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, 2, "case5_next");
    endtask

    task automatic test_back_to_back();
        run(32'h0100_0000, 32'h00FF_FFFF, 1'b0, 3'b010, 2, "b2b_first");
        run(32'h1234_5600, 32'h1234_5601, 1'b0, 3'b001, 5, "b2b_second");
        run(32'h8000_0001, 32'h0000_0001, 1'b1, 3'b001, 2, "b2b_neg");
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        seen = 1'b0;
        out_ready = 1'b1;
        a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; sgn = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL case6_rst_in_ready: got %b expected 0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL case6_idle: in_ready got %b expected 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL case6_no_out_valid: got %b expected 0", seen);
        end
    endtask

`ifdef BR_FUNCT_EN
    task automatic test_branch();
        out_ready = 1'b1;
        start_and_wait(32'hFFFF_FFFB, 32'h3, 1'b0, 3'b101, 3'b001, 2, 1'b0, "case7_bge");
        finish_handshake("case7_bge");
        start_and_wait(32'hFFFF_FFFB, 32'h3, 1'b1, 3'b111, 3'b010, 2, 1'b1, "case7_bgeu");
        finish_handshake("case7_bgeu");
        start_and_wait(32'h5, 32'h5, 1'b0, 3'b000, 3'b100, 5, 1'b1, "beq");
        finish_handshake("beq");
        start_and_wait(32'h5, 32'h5, 1'b0, 3'b001, 3'b100, 5, 1'b0, "bne");
        finish_handshake("bne");
        start_and_wait(32'hFFFF_FFFB, 32'h3, 1'b1, 3'b100, 3'b001, 2, 1'b1, "blt");
        finish_handshake("blt");
        start_and_wait(32'h1, 32'h2, 1'b0, 3'b010, 3'b001, 5, 1'b0, "illegal_010");
        finish_handshake("illegal_010");
    endtask
`endif

    initial begin
        test_reset();
        test_compare();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef BR_FUNCT_EN
        test_branch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
